// File: rtl/gpr_wb_arbiter_if.sv
// Write-back bus between the ALU/load requesters and the GPR write port.
// The master side drives requests and stall; the slave side is the arbiter.
interface gpr_wb_arbiter_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
);
   logic              alu_valid;
   logic [ADDR_W-1:0] alu_dest;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ready;
   logic              mem_valid;
   logic [ADDR_W-1:0] mem_dest;
   logic [DATA_W-1:0] mem_data;
   logic              mem_ready;
   logic              wb_stall;
   logic              reg_write_en;
   logic [ADDR_W-1:0] reg_write_dest;
   logic [DATA_W-1:0] reg_write_data;

   modport master (
      output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data, wb_stall,
      input  alu_ready, mem_ready, reg_write_en, reg_write_dest, reg_write_data
   );

   modport slave (
      input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data, wb_stall,
      output alu_ready, mem_ready, reg_write_en, reg_write_dest, reg_write_data
   );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// Round-robin write-back arbiter for the 8x8 GPR write port, with a busy
// scoreboard for RAW hazard detection and a saturating commit counter.
module gpr_wb_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int NREG   = 8
) (
   input  logic              clk,
   input  logic              rst,
   gpr_wb_arbiter_if.slave   wb,
   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_dest,
   input  logic [ADDR_W-1:0] chk_addr_1,
   input  logic [ADDR_W-1:0] chk_addr_2,
   output logic              chk_busy_1,
   output logic              chk_busy_2,
   output logic [NREG-1:0]   busy_mask,
   output logic [15:0]       wb_count
);

   logic              last_alu_q, last_alu_d;
   logic              reg_write_en_q, reg_write_en_d;
   logic [ADDR_W-1:0] reg_write_dest_q, reg_write_dest_d;
   logic [DATA_W-1:0] reg_write_data_q, reg_write_data_d;
   logic [NREG-1:0]   busy_mask_q, busy_mask_d;
   logic [15:0]       wb_count_q, wb_count_d;
   logic              alu_req_s, mem_req_s;
   logic              grant_alu_s, grant_mem_s;

   // On contention the requester not served last wins; last_alu_q tracks that.
   always_comb begin
      alu_req_s   = wb.alu_valid && !wb.wb_stall;
      mem_req_s   = wb.mem_valid && !wb.wb_stall;
      grant_alu_s = alu_req_s && (!mem_req_s || !last_alu_q);
      grant_mem_s = mem_req_s && (!alu_req_s || last_alu_q);

      last_alu_d       = last_alu_q;
      reg_write_en_d   = grant_alu_s || grant_mem_s;
      reg_write_dest_d = reg_write_dest_q;
      reg_write_data_d = reg_write_data_q;
      if (grant_alu_s) begin
         last_alu_d       = 1'b1;
         reg_write_dest_d = wb.alu_dest;
         reg_write_data_d = wb.alu_data;
      end else if (grant_mem_s) begin
         last_alu_d       = 1'b0;
         reg_write_dest_d = wb.mem_dest;
         reg_write_data_d = wb.mem_data;
      end else begin
         last_alu_d = last_alu_q;
      end
   end

   // A new issue to a register supersedes a write retiring to it on the same edge.
   always_comb begin
      busy_mask_d = busy_mask_q;
      for (int i = 0; i < NREG; i++) begin
         if (issue_en && (issue_dest == ADDR_W'(i))) begin
            busy_mask_d[i] = 1'b1;
         end else if (reg_write_en_q && (reg_write_dest_q == ADDR_W'(i))) begin
            busy_mask_d[i] = 1'b0;
         end else begin
            busy_mask_d[i] = busy_mask_q[i];
         end
      end
   end

   always_comb begin
      wb_count_d = wb_count_q;
      if (reg_write_en_q && (wb_count_q != 16'hFFFF)) begin
         wb_count_d = wb_count_q + 16'd1;
      end else begin
         wb_count_d = wb_count_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_alu_q       <= 1'b1;
         reg_write_en_q   <= 1'b0;
         reg_write_dest_q <= {ADDR_W{1'b0}};
         reg_write_data_q <= {DATA_W{1'b0}};
         busy_mask_q      <= {NREG{1'b0}};
         wb_count_q       <= 16'd0;
      end else begin
         last_alu_q       <= last_alu_d;
         reg_write_en_q   <= reg_write_en_d;
         reg_write_dest_q <= reg_write_dest_d;
         reg_write_data_q <= reg_write_data_d;
         busy_mask_q      <= busy_mask_d;
         wb_count_q       <= wb_count_d;
      end
   end

   assign wb.alu_ready      = grant_alu_s;
   assign wb.mem_ready      = grant_mem_s;
   assign wb.reg_write_en   = reg_write_en_q;
   assign wb.reg_write_dest = reg_write_dest_q;
   assign wb.reg_write_data = reg_write_data_q;
   assign busy_mask         = busy_mask_q;
   assign wb_count          = wb_count_q;
   assign chk_busy_1        = busy_mask_q[chk_addr_1];
   assign chk_busy_2        = busy_mask_q[chk_addr_2];

endmodule

// File: doc/gpr_wb_arbiter.md
# gpr_wb_arbiter

Write-back arbiter and register scoreboard for the 8x8-bit general purpose register file. It shares the file's single write port between the ALU and the load/memory write-back paths using round-robin arbitration with a valid/ready handshake. It tracks in-flight destination registers in a busy scoreboard so the issue logic can detect read-after-write hazards. It sits between the execute/memory stages and the GPR write port (`reg_write_en`/`reg_write_dest`/`reg_write_data`).

## Interface
- `DATA_W`, 8, write data width
- `ADDR_W`, 3, register address width
- `NREG`, 8, number of registers (2**ADDR_W)

- `clk` in 1: single clock, all state updates on posedge
- `rst` in 1: synchronous, active-high reset
- `alu_valid` in 1: ALU write-back request
- `alu_dest` in ADDR_W: ALU destination register
- `alu_data` in DATA_W: ALU result
- `alu_ready` out 1: ALU request accepted this cycle
- `mem_valid` in 1: load write-back request
- `mem_dest` in ADDR_W: load destination register
- `mem_data` in DATA_W: load data
- `mem_ready` out 1: load request accepted this cycle
- `wb_stall` in 1: block all grants this cycle
- `issue_en` in 1: instruction issued that will write `issue_dest`
- `issue_dest` in ADDR_W: register to mark busy
- `chk_addr_1`, `chk_addr_2` in ADDR_W: source operands to check
- `chk_busy_1`, `chk_busy_2` out 1: combinational busy bit of the checked register
- `busy_mask` out NREG: registered scoreboard, bit i = register i pending
- `reg_write_en` out 1: to GPR file write enable (registered)
- `reg_write_dest` out ADDR_W: to GPR file write address (registered)
- `reg_write_data` out DATA_W: to GPR file write data (registered)
- `wb_count` out 16: number of committed writes, saturates at 16'hFFFF

## Operation
- Handshake: a transfer occurs in a cycle where `X_valid && X_ready`. The requester must hold valid, dest, and data stable until ready. `X_ready` is combinational from valid, `wb_stall`, and the pointer. It never depends on itself.
- Arbitration: at most one ready per cycle. If `wb_stall` is high, both ready signals are 0.
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not granted last. A 1-bit pointer `last_alu` is updated on every transfer.
- Reset value of `last_alu` is 1, so mem wins the first contention.
- Commit register: on a transfer, the next edge loads `reg_write_en`=1 plus the granted dest and data. With no transfer, the next edge loads `reg_write_en`=0; dest and data hold their previous values.
- All registers are writable; there is no hardwired zero register.
- Scoreboard, per bit i at each edge:
  - Set if `issue_en && issue_dest==i`.
  - Else clear if `reg_write_en && reg_write_dest==i`.
  - Else hold.
  - Set wins over a simultaneous clear of the same register, because the new issue supersedes the old write.
- `chk_busy_n` = `busy_mask[chk_addr_n]`, so a register reads not-busy in the cycle after its GPR write edge.
- Same-dest requests from both paths are written in grant order, so the later grant's data is the final value.
- `wb_count` increments at each edge where `reg_write_en`=1, saturating at 16'hFFFF.
- Reset: `reg_write_en`=0, `reg_write_dest`=0, `reg_write_data`=0, `busy_mask`=0, `wb_count`=0, `last_alu`=1. Ready outputs follow the combinational rules. Reset asserted mid-transfer discards the pending commit, and no write occurs in the cycle after reset.

## Timing
- Accept-to-write latency is 1 cycle:
  - Transfer in cycle N.
  - `reg_write_en` high in cycle N+1.
  - GPR file and scoreboard update at the end-of-N+1 edge.
- Sustained throughput is one write per cycle. Under continuous dual requests, grants alternate mem, alu, mem, alu, and so on.
- `wb_stall` takes effect in the same cycle. A commit already registered still completes.
- Scoreboard set takes effect in cycle N+1 for `issue_en` in cycle N.

## Test plan
- Reset, then single ALU request, dest=3, data=8'h5A, in cycle 1 → `alu_ready`=1 in cycle 1; cycle 2: `reg_write_en`=1, dest=3, data=8'h5A; `wb_count`=1 in cycle 3.
- Both valid for 4 cycles (alu dest 1, mem dest 2) → grants mem, alu, mem, alu; exactly one ready per cycle; never both.
- `wb_stall`=1 for 3 cycles with both valid → both ready=0 and no writes. After stall drops, mem or alu is granted per `last_alu`, and requests held stable are accepted unchanged.
- `issue_en` dest=5 → `busy_mask`=8'h20 and `chk_busy_1`=1 for addr 5. Mem write to 5 commits → bit clears at the write edge. Issue to 5 on that same edge → bit stays 1.
- `rst` asserted in the cycle after a transfer → `reg_write_en`=0 next cycle, `busy_mask`=0, `wb_count`=0, and the first contention afterward grants mem.
- Force `wb_count` to 16'hFFFE, commit 3 writes → value ends at 16'hFFFF.
